traffic_scheduler: RTL and testbench

Central sequencer for the oncoming-car sprites. It owns NUM_CARS car slots and decides when each slot spawns, which lane it uses, and how far it moves per step. It also tracks dodged-car score and level, and freezes traffic on collision. Its outputs drive the per-car sprite renderers (x, y, enable) and the road/score display logic.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_lane_gen.sv | 45 ++++
 rtl/traffic_scheduler.sv | 155 +++++++++++++++
 tb/tb_traffic_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, tables and state type for the traffic scheduler
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_t;

    // Entry 3 repeats lane 0 so a raw 2-bit lane index can never select outside the road
    localparam logic [9:0] LANE_X [4] = '{10'd170, 10'd300, 10'd430, 10'd170};

    localparam logic [2:0] STEPS_PER_LEVEL [4] = '{3'd6, 3'd4, 3'd3, 3'd2};

    localparam logic [5:0] LVL1_MIN = 6'd10;
    localparam logic [5:0] LVL2_MIN = 6'd20;
    localparam logic [5:0] LVL3_MIN = 6'd35;

    function automatic logic [1:0] level_of(input logic [5:0] score);
        if (score < LVL1_MIN)      return 2'd0;
        else if (score < LVL2_MIN) return 2'd1;
        else if (score < LVL3_MIN) return 2'd2;
        else                       return 2'd3;
    endfunction

endpackage

// File: rtl/traffic_lane_gen.sv
// rtl/traffic_lane_gen.sv - lane picker for new cars; RANDOM_LANE_EN selects LFSR, else round-robin
module traffic_lane_gen
    import traffic_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_advance,
    input  logic       i_next,
    output logic [1:0] o_lane
);

`ifdef RANDOM_LANE_EN
    logic [2:0] r_lfsr;
    logic [1:0] r_last;
    logic [1:0] w_raw;
    logic [1:0] w_lane;

    assign w_raw  = (r_lfsr[1:0] == 2'd3) ? 2'd0 : r_lfsr[1:0];
    // Never repeat the previous lane back to back
    assign w_lane = (w_raw != r_last) ? w_raw : ((w_raw == 2'd2) ? 2'd0 : w_raw + 2'd1);
    assign o_lane = w_lane;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= 3'b101;
            r_last <= 2'd3;
        end else begin
            if (i_advance) r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
            if (i_next)    r_last <= w_lane;
        end
    end
`else
    logic [1:0] r_rr;
    logic       w_unused;

    assign w_unused = i_advance;
    assign o_lane   = r_rr;

    always_ff @(posedge i_clk) begin
        if (i_reset)     r_rr <= 2'd0;
        else if (i_next) r_rr <= (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
    end
`endif

endmodule

// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - spawns, moves and retires traffic car slots; tracks score/level/crash
// Lane choice is random when RANDOM_LANE_EN is defined, round-robin otherwise.
module traffic_scheduler
    import traffic_pkg::*;
#(
    parameter int NUM_CARS  = 4,
    parameter int TICK_DIV  = 200000,
    parameter int STEP_PX   = 4,
    parameter int SCREEN_H  = 480,
    parameter int SPAWN_GAP = 100,
    parameter int MAX_SCORE = 50
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_collision,
    output logic [10*NUM_CARS-1:0] o_car_x,
    output logic [10*NUM_CARS-1:0] o_car_y,
    output logic [NUM_CARS-1:0]   o_car_en,
    output logic [5:0]            o_score,
    output logic [1:0]            o_level,
    output logic                  o_game_over
);

    localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [9:0] Y_EXIT    = 10'(SCREEN_H);
    localparam logic [9:0] Y_GAP     = 10'(SPAWN_GAP);
    localparam logic [9:0] Y_STEP    = 10'(STEP_PX);
    localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);

    state_t              r_state;
    state_t              w_next_state;
    logic [PW-1:0]       r_presc;
    logic [2:0]          r_step_cnt;
    logic [5:0]          r_score;
    logic [1:0]          r_level;
    logic                r_game_over;

    logic                w_run;
    logic                w_tick;
    logic                w_step_due;
    logic                w_step;
    logic                w_spawn_ok;
    logic                w_spawn;
    logic [1:0]          w_lane;
    logic [NUM_CARS-1:0] w_en;
    logic [NUM_CARS-1:0] w_exit;
    logic [NUM_CARS-1:0] w_blocking;
    logic [NUM_CARS-1:0] w_spawn_sel;
    logic [3:0]          w_exit_cnt;
    logic [6:0]          w_score_sum;
    logic [5:0]          w_score_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = RUN;
            RUN:     if (i_collision) w_next_state = CRASH;
            CRASH:   w_next_state = CRASH;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_tick     = w_run && (r_presc == TICK_LAST);
    assign w_step_due = w_tick && (r_step_cnt == STEPS_PER_LEVEL[r_level]);
    // A collision in the same cycle wins: the pending step is dropped
    assign w_step     = w_step_due && !i_collision;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc    <= '0;
            r_step_cnt <= '0;
        end else if (w_run) begin
            r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 1'b1;
            if (w_tick) r_step_cnt <= w_step_due ? 3'd0 : r_step_cnt + 3'd1;
        end
    end

    // Lowest clear bit of the pre-step enable vector is the spawn target
    assign w_spawn_sel = ~w_en & (w_en + 1'b1);
    assign w_spawn_ok  = ~|w_blocking;
    assign w_spawn     = w_step && w_spawn_ok && (w_spawn_sel != '0);

    always_comb begin
        w_exit_cnt = 4'd0;
        for (int i = 0; i < NUM_CARS; i++) w_exit_cnt = w_exit_cnt + {3'b000, w_exit[i]};
    end

    assign w_score_sum  = {1'b0, r_score} + {3'b000, w_exit_cnt};
    assign w_score_next = (w_score_sum > SCORE_MAX) ? SCORE_MAX[5:0] : w_score_sum[5:0];

    traffic_lane_gen u_lane_gen (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_advance (w_run),
        .i_next    (w_spawn),
        .o_lane    (w_lane)
    );

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_slot
        logic [9:0] r_x;
        logic [9:0] r_y;
        logic       r_en;

        assign w_en[g]       = r_en;
        assign w_exit[g]     = r_en && (r_y > Y_EXIT);
        assign w_blocking[g] = r_en && (r_y < Y_GAP);
        assign o_car_x[10*g +: 10] = r_x;
        assign o_car_y[10*g +: 10] = r_y;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_x  <= LANE_X[0];
                r_y  <= 10'd0;
                r_en <= 1'b0;
            end else if (w_step) begin
                if (w_exit[g]) begin
                    r_en <= 1'b0;
                    r_y  <= 10'd0;
                end else if (r_en) begin
                    r_y <= r_y + Y_STEP;
                end else if (w_spawn && w_spawn_sel[g]) begin
                    r_en <= 1'b1;
                    r_y  <= 10'd0;
                    r_x  <= LANE_X[w_lane];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_score     <= 6'd0;
            r_level     <= 2'd0;
            r_game_over <= 1'b0;
        end else begin
            if (w_step) r_score <= w_score_next;
            r_level     <= level_of(r_score);
            r_game_over <= (w_next_state == CRASH);
        end
    end

    assign o_car_en    = w_en;
    assign o_score     = r_score;
    assign o_level     = r_level;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - directed bench with a behavioural traffic model checked every cycle
module tb_traffic_scheduler;

    localparam int NC = 4;
    localparam int TD = 2;
    localparam int SP = 4;
    localparam int SH = 120;
    localparam int SG = 20;
    localparam int MS = 50;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             collision;
    logic [10*NC-1:0] car_x;
    logic [10*NC-1:0] car_y;
    logic [NC-1:0]    car_en;
    logic [5:0]       score;
    logic [1:0]       level;
    logic             game_over;

    traffic_scheduler #(
        .NUM_CARS(NC), .TICK_DIV(TD), .STEP_PX(SP),
        .SCREEN_H(SH), .SPAWN_GAP(SG), .MAX_SCORE(MS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_collision (collision),
        .o_car_x     (car_x),
        .o_car_y     (car_y),
        .o_car_en    (car_en),
        .o_score     (score),
        .o_level     (level),
        .o_game_over (game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: 0=idle 1=run 2=crash
    int m_state, m_run_cycles, m_ticks, m_score, m_level, m_spawns;
    int m_y [NC];
    int m_x [NC];
    bit m_en [NC];
    bit m_go;
    bit m_fire;
    int m_lvl_next;
    int lanes [3] = '{170, 300, 430};
    bit chk_on = 1'b0;

    function automatic int steps_for(input int lvl);
        case (lvl)
            0:       return 6;
            1:       return 4;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int level_for(input int s);
        if (s < 10) return 0;
        if (s < 20) return 1;
        if (s < 35) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run_cycles = 0; m_ticks = 0; m_score = 0; m_level = 0; m_spawns = 0; m_go = 0;
        for (int i = 0; i < NC; i++) begin m_y[i] = 0; m_x[i] = 170; m_en[i] = 0; end
    endtask

    task automatic model_step();
        int exits;
        int free;
        bit ok;
        bit pre_en [NC];
        exits = 0; free = -1; ok = 1;
        for (int i = 0; i < NC; i++) begin
            pre_en[i] = m_en[i];
            if (m_en[i]) begin
                if (m_y[i] < SG) ok = 0;
                if (m_y[i] > SH) exits++;
            end else if (free < 0) begin
                free = i;
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (pre_en[i]) begin
                if (m_y[i] > SH) begin m_en[i] = 0; m_y[i] = 0; end
                else m_y[i] = m_y[i] + SP;
            end
        end
        if (ok && free >= 0) begin
            m_en[free] = 1; m_y[free] = 0; m_x[free] = lanes[m_spawns % 3]; m_spawns++;
        end
        m_score = (m_score + exits > MS) ? MS : m_score + exits;
    endtask

    function automatic bit step_due_next();
        return (m_state == 1) && ((m_run_cycles + 1) % TD == 0) && (m_ticks == steps_for(m_level));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            m_lvl_next = level_for(m_score);
            m_fire = 0;
            if (m_state == 1) begin
                m_run_cycles++;
                if (m_run_cycles % TD == 0) begin
                    if (m_ticks == steps_for(m_level)) begin m_fire = 1; m_ticks = 0; end
                    else m_ticks++;
                end
                if (collision) begin m_state = 2; m_fire = 0; end
                if (m_fire) model_step();
            end else if (m_state == 0 && start) begin
                m_state = 1;
            end
            m_level = m_lvl_next;
            m_go = (m_state == 2);
        end
    end

    logic [10*NC-1:0] e_x, e_y;
    logic [NC-1:0]    e_en;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NC; i++) begin
                e_x[10*i +: 10] = 10'(m_x[i]);
                e_y[10*i +: 10] = 10'(m_y[i]);
                e_en[i]         = m_en[i];
            end
            check("car_x", 64'(car_x), 64'(e_x));
            check("car_y", 64'(car_y), 64'(e_y));
            check("car_en", 64'(car_en), 64'(e_en));
            check("score", 64'(score), 64'(m_score));
            check("level", 64'(level), 64'(m_level));
            check("game_over", 64'(game_over), 64'(m_go));
        end
    end

    task automatic check_reset_values(input string tag);
        logic [10*NC-1:0] rx;
        rx = {NC{10'd170}};
        check({tag, "_x"}, 64'(car_x), 64'(rx));
        check({tag, "_y"}, 64'(car_y), 64'd0);
        check({tag, "_en"}, 64'(car_en), 64'd0);
        check({tag, "_score"}, 64'(score), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_go"}, 64'(game_over), 64'd0);
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    int n;

    initial begin
        reset = 1'b1; start = 1'b0; collision = 1'b0;
        @(posedge clk); #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Start: first step lands 2*(6+1) cycles after entering RUN
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (car_en != '0) break;
        end
        check("first_step_cycles", 64'(n), 64'd14);
        check("first_en", 64'(car_en), 64'h1);
        check("first_x0", 64'(car_x[9:0]), 64'd170);
        check("first_y0", 64'(car_y[9:0]), 64'd0);

        // Second spawn only once slot0 has reached the spawn gap
        n = 0;
        while (n < 2000 && !car_en[1]) begin @(negedge clk); n++; end
        if (n >= 2000) timeout("second_spawn");
        check("second_y0", 64'(car_y[9:0]), 64'd24);
        check("second_x1", 64'(car_x[19:10]), 64'd300);
        check("second_y1", 64'(car_y[19:10]), 64'd0);

        // All slots busy; later spawns must wait for a freed slot
        n = 0;
        while (n < 3000 && car_en != 4'hf) begin @(negedge clk); n++; end
        if (n >= 3000) timeout("all_full");
        check("full_x2", 64'(car_x[29:20]), 64'd430);
        check("full_x3", 64'(car_x[39:30]), 64'd170);

        // Level follows score one cycle later
        n = 0;
        while (n < 20000 && score < 6'd10) begin @(negedge clk); n++; end
        if (n >= 20000) timeout("score10");
        check("score10_val", 64'(score), 64'd10);
        check("score10_level_lag", 64'(level), 64'd0);
        @(negedge clk);
        check("score10_level", 64'(level), 64'd1);

        // Saturation
        n = 0;
        while (n < 40000 && score != 6'd50) begin @(negedge clk); n++; end
        if (n >= 40000) timeout("score50");
        check("sat_level", 64'(level), 64'd3);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("sat_score", 64'(score), 64'd50);

        // Collision coinciding with a step freezes everything
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (step_due_next()) begin collision = 1'b1; break; end
        end
        if (n >= 100) timeout("step_for_collision");
        @(posedge clk); #1 collision = 1'b0; start = 1'b1;
        @(negedge clk);
        check("crash_go", 64'(game_over), 64'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("crash_hold_go", 64'(game_over), 64'd1);
        check("crash_hold_score", 64'(score), 64'd50);

        @(posedge clk); #1 reset = 1'b1; start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("rereset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
